// File: rtl/phase_bus_scheduler_if.sv
// Command handshake between the command parser and the phase-bus scheduler.
// The parser drives the command fields; the scheduler answers with ready.
interface phase_bus_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode;
  logic [39:0] cmd_params;
  logic [1:0]  cmd_type;

  modport master (output cmd_valid, cmd_opcode, cmd_params, cmd_type, input cmd_ready);
  modport slave  (input cmd_valid, cmd_opcode, cmd_params, cmd_type, output cmd_ready);
endinterface

// File: rtl/phase_bus_scheduler.sv
// Phase-bus scheduler: runs one engine at a time with a run timeout, a release
// handshake and an idle gap on the phase bus between operations.
module phase_bus_scheduler #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int TIMEOUT_CYCLES  = 27000,
  parameter int GAP_CYCLES      = 21
) (
  input  logic                        clock,
  input  logic                        reset,
  phase_bus_scheduler_if.slave        cmd,
  input  logic                        tx_busy,
  output logic                        lamp_card_reset_activate,
  output logic                        substate_pb_i_write4_active,
  output logic                        substate_pb_read4_active,
  output logic                        substate_pb_adc4_active,
  input  logic                        lamp_card_reset_complete,
  input  logic                        substate_pb_i_write4_complete,
  input  logic                        substate_pb_read4_complete,
  input  logic                        substate_pb_adc4_complete,
  output logic [39:0]                 command_param_data,
  output logic [1:0]                  CommandType,
  output logic                        busy,
  output logic                        error,
  output logic [1:0]                  error_code,
  output logic [7:0]                  cmd_count
);
  // state    | meaning
  // INIT_RUN | lamp card reset engine running after reset
  // INIT_GAP | bus idle gap after the power-up reset
  // IDLE     | waiting for a command
  // ACTIVE   | selected engine running
  // RELEASE  | activate dropped, waiting for the engine to drop complete
  // GAP      | bus idle gap after a command or abort
  // ABORT    | timeout seen, error raised, going to GAP

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  // The gap never shrinks below 750 ns, whatever GAP_CYCLES is set to.
  localparam longint MIN_GAP = (longint'(CLOCK_FREQUENCY) * 64'sd750 + 64'sd999_999_999)
                               / 64'sd1_000_000_000;
  localparam int GAP_EFF = (longint'(GAP_CYCLES) > MIN_GAP) ? GAP_CYCLES : int'(MIN_GAP);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_EFF - 1);

  typedef enum logic [2:0] {
    S_INIT_RUN, S_INIT_GAP, S_IDLE, S_ACTIVE, S_RELEASE, S_GAP, S_ABORT
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic [1:0]    opcode;
  logic          in_init;
  logic [3:0]    complete_vec, act, act_next;
  logic          sel_complete, timer_done, ready, accept, op_done;

  assign complete_vec = {substate_pb_adc4_complete, substate_pb_read4_complete,
                         substate_pb_i_write4_complete, lamp_card_reset_complete};
  // opcode resets to 0, so during power-up the lamp engine is the selected one.
  assign sel_complete  = complete_vec[opcode];
  assign timer_done    = (timer == TIMER_LAST);
  assign ready         = (state == S_IDLE) && !tx_busy;
  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_valid && ready;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_INIT_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    act_next   = '0;
    op_done    = 1'b0;
    case (state)
      S_INIT_RUN: begin
        if (lamp_card_reset_complete) state_next = S_RELEASE;
        else if (timer_done)          state_next = S_ABORT;
      end
      S_INIT_GAP, S_GAP: begin
        if (timer == GAP_LAST) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (accept) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (sel_complete) begin
          state_next = S_RELEASE;
          op_done    = 1'b1;
        end else if (timer_done) begin
          state_next = S_ABORT;
        end
      end
      S_RELEASE: begin
        if (!sel_complete)   state_next = in_init ? S_INIT_GAP : S_GAP;
        else if (timer_done) state_next = S_ABORT;
      end
      S_ABORT:  state_next = S_GAP;
      default:  state_next = S_INIT_RUN;
    endcase
    // Activates are registered from the next state so reset clears them at once.
    case (state_next)
      S_INIT_RUN: act_next = 4'b0001;
      S_ACTIVE:   act_next = 4'b0001 << (accept ? cmd.cmd_opcode : opcode);
      default:    act_next = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state_next != state || state == S_IDLE) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act                <= '0;
      opcode             <= '0;
      in_init            <= 1'b1;
      command_param_data <= '0;
      CommandType        <= '0;
      error              <= 1'b0;
      error_code         <= '0;
      cmd_count          <= '0;
    end else begin
      act <= act_next;
      if (accept) begin
        opcode             <= cmd.cmd_opcode;
        command_param_data <= cmd.cmd_params;
        CommandType        <= cmd.cmd_type;
        error              <= 1'b0;
        error_code         <= 2'd0;
      end
      if (state_next == S_IDLE) in_init <= 1'b0;
      if (op_done) cmd_count <= cmd_count + 8'd1;
      if (state != S_ABORT && state_next == S_ABORT) begin
        error      <= 1'b1;
        error_code <= in_init ? 2'd2 : 2'd1;
      end
    end
  end

  assign lamp_card_reset_activate    = act[0];
  assign substate_pb_i_write4_active = act[1];
  assign substate_pb_read4_active    = act[2];
  assign substate_pb_adc4_active     = act[3];
endmodule

// File: tb/tb_phase_bus_scheduler.sv
// Bench for phase_bus_scheduler: randomized commands against a reference model,
// with a scoreboard queue checked by an independent monitor.
module tb_phase_bus_scheduler;
  localparam int TO  = 64;
  localparam int GAP = 21;

  logic        clock = 1'b0;
  logic        reset;
  logic        tx_busy;
  logic [3:0]  comp;
  logic        lamp_act, w4_act, r4_act, a4_act;
  logic [39:0] cpd;
  logic [1:0]  ctype_o;
  logic        busy, error;
  logic [1:0]  error_code;
  logic [7:0]  cmd_count;

  phase_bus_scheduler_if bus ();

  phase_bus_scheduler #(
    .CLOCK_FREQUENCY(27000000),
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES(GAP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd(bus),
    .tx_busy(tx_busy),
    .lamp_card_reset_activate(lamp_act),
    .substate_pb_i_write4_active(w4_act),
    .substate_pb_read4_active(r4_act),
    .substate_pb_adc4_active(a4_act),
    .lamp_card_reset_complete(comp[0]),
    .substate_pb_i_write4_complete(comp[1]),
    .substate_pb_read4_complete(comp[2]),
    .substate_pb_adc4_complete(comp[3]),
    .command_param_data(cpd),
    .CommandType(ctype_o),
    .busy(busy),
    .error(error),
    .error_code(error_code),
    .cmd_count(cmd_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [39:0] params;
    logic [1:0]  ctype;
    int          act_len;
    logic [7:0]  count;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_count = 8'd0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Monitor: opens a record on each accept, closes it when the block is idle again.
  bit         in_op = 1'b0;
  bit         first_cyc;
  int         act_len, stray;
  exp_t       cur;
  logic [3:0] acts;

  always @(negedge clock) begin
    if (mon_en) begin
      if (in_op) begin
        acts = {a4_act, r4_act, w4_act, lamp_act};
        if ((acts & ~(4'b0001 << cur.op)) != 4'b0000) stray++;
        if (acts[cur.op]) act_len++;
        if (first_cyc) begin
          chk("err_cleared_on_accept", {error, error_code}, 3'b000);
          first_cyc = 1'b0;
        end
        if (!busy) begin
          chk("act_len", act_len, cur.act_len);
          chk("stray_activate", stray, 0);
          chk("cmd_count", cmd_count, cur.count);
          chk("error", error, cur.err);
          chk("error_code", error_code, cur.code);
          chk("param_data", cpd, cur.params);
          chk("command_type", ctype_o, cur.ctype);
          void'(q.pop_front());
          in_op = 1'b0;
        end
      end
      if (!in_op && bus.cmd_valid && bus.cmd_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          cur       = q[0];
          in_op     = 1'b1;
          first_cyc = 1'b1;
          act_len   = 0;
          stray     = 0;
        end
      end
    end
  end

  // Reference model: engine completes d cycles after start; runs past TO cycles time out.
  task automatic push_expected(input logic [1:0] op, input logic [39:0] p,
                               input logic [1:0] t, input int d);
    exp_t e;
    bit   timed_out;
    timed_out = (d > TO);
    if (!timed_out) model_count = model_count + 8'd1;
    e.op      = op;
    e.params  = p;
    e.ctype   = t;
    e.act_len = (d < TO) ? d : TO;
    e.count   = model_count;
    e.err     = timed_out;
    e.code    = timed_out ? 2'd1 : 2'd0;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < 4 * TO + 200);
    if (busy) begin
      chk(name, busy, 0);
      $fatal(1, "bench stopped: scheduler never returned to idle");
    end
  endtask

  // Issues one command and plays the selected engine; returns at posedge+1.
  task automatic run_op(input logic [1:0] op, input logic [39:0] p, input logic [1:0] t,
                        input int d, input int h, input bit spur, input bit hold_tx);
    int         n;
    logic [1:0] other;
    other = op + 2'd3;
    push_expected(op, p, t, d);
    if (hold_tx) begin
      wait_idle("idle_before_tx_busy_test");
      @(posedge clock); #1;
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_params = p;
    bus.cmd_type   = t;
    if (hold_tx) begin
      tx_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clock);
        chk("ready_while_tx_busy", bus.cmd_ready, 0);
        @(posedge clock); #1;
      end
      tx_busy = 1'b0;
      @(negedge clock);
      chk("ready_after_tx_drop", bus.cmd_ready, 1);
    end else begin
      n = 0;
      forever begin
        tx_busy = ($urandom_range(0, 3) == 0);
        @(negedge clock);
        if (bus.cmd_ready) break;
        @(posedge clock); #1;
        n++;
        if (n > 4 * TO + 200) begin
          chk("accept_wait", 0, 1);
          $fatal(1, "bench stopped: command never accepted");
        end
      end
    end
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    tx_busy       = 1'b0;
    if (spur && d >= 3) begin
      comp[other] = 1'b1;
      @(posedge clock); #1;
      comp[other] = 1'b0;
      repeat (d - 2) @(posedge clock);
      #1;
    end else begin
      repeat (d - 1) @(posedge clock);
      #1;
    end
    comp[op] = 1'b1;
    repeat (h) begin
      @(posedge clock); #1;
    end
    comp[op] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int         lamp_cnt, gap_cnt, d, h;
    bit         idle_seen;
    logic [1:0] op;
    reset          = 1'b1;
    tx_busy        = 1'b0;
    comp           = 4'b0000;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = 2'd0;
    bus.cmd_params = 40'd0;
    bus.cmd_type   = 2'd0;
    repeat (3) @(negedge clock);
    chk("rst_activates", {a4_act, r4_act, w4_act, lamp_act}, 4'b0000);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_error", {error, error_code}, 3'b000);
    chk("rst_count", cmd_count, 0);
    chk("rst_params", {ctype_o, cpd}, 42'd0);
    reset = 1'b0;

    // Power-up: lamp complete pulsed in cycle 5.
    lamp_cnt  = 0;
    gap_cnt   = 0;
    idle_seen = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clock);
      if (cyc == 1) chk("first_lamp_activate", lamp_act, 1);
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
      lamp_cnt += int'(lamp_act);
      if (!lamp_act) gap_cnt++;
      comp[0] = (cyc == 5);
    end
    comp[0] = 1'b0;
    chk("init_reaches_idle", idle_seen, 1);
    chk("init_lamp_cycles", lamp_cnt, 5);
    chk("init_release_plus_gap", gap_cnt, GAP + 1);
    chk("init_ready", bus.cmd_ready, 1);
    chk("init_count", cmd_count, 0);
    chk("init_error", error, 0);

    mon_en = 1'b1;
    @(posedge clock); #1;
    run_op(2'd2, 40'h01_0203_0405, 2'd1, 10, 1, 1'b0, 1'b0);
    run_op(2'd1, {$urandom, $urandom}, 2'd2, TO + 1, 2, 1'b0, 1'b0);
    run_op(2'd3, {$urandom, $urandom}, 2'd0, 12, 2, 1'b1, 1'b1);
    run_op(2'd0, {$urandom, $urandom}, 2'd3, TO, 1, 1'b1, 1'b0);
    run_op(2'd2, {$urandom, $urandom}, 2'd1, TO - 1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 340; i++) begin
      op = 2'($urandom_range(0, 3));
      if (i % 10 == 0)      d = TO + $urandom_range(1, 4);
      else if (i % 10 == 5) d = TO - $urandom_range(0, 2);
      else                  d = $urandom_range(1, 20);
      h = $urandom_range(1, 3);
      run_op(op, {$urandom, $urandom}, 2'($urandom_range(0, 3)), d, h,
             bit'($urandom_range(0, 1)), 1'b0);
    end
    for (int k = 0; k < 4 * TO + 200 && q.size() != 0; k++) @(negedge clock);
    chk("scoreboard_drained", q.size(), 0);
    mon_en = 1'b0;

    // Reset during an active write4, then a power-up whose lamp engine never completes.
    wait_idle("idle_before_reset_test");
    @(posedge clock); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 2'd1;
    bus.cmd_params = 40'hA5_5A5A_A5A5;
    @(negedge clock);
    chk("ready_before_reset_op", bus.cmd_ready, 1);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clock);
    chk("write4_active_before_reset", w4_act, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_activate_drop", {a4_act, r4_act, w4_act, lamp_act}, 4'b0000);
    chk("async_busy", busy, 1);
    chk("async_count_clear", cmd_count, 0);
    chk("async_params_clear", cpd, 40'd0);
    @(negedge clock);
    reset     = 1'b0;
    idle_seen = 1'b0;
    for (int cyc = 1; cyc <= TO + GAP + 100; cyc++) begin
      @(negedge clock);
      if (cyc == 1) chk("repeat_first_lamp_activate", lamp_act, 1);
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
    end
    chk("init_timeout_reaches_idle", idle_seen, 1);
    chk("init_timeout_error", error, 1);
    chk("init_timeout_code", error_code, 2);
    chk("init_timeout_count", cmd_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/phase_bus_scheduler.md
PHASE_BUS_SCHEDULER -- requirements
Module: phase_bus_scheduler

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 27000000, system clock frequency in Hz.
REQ-002 Parameter TIMEOUT_CYCLES, default 27000, maximum engine run time in clocks (1 ms at 27 MHz).
REQ-003 Parameter GAP_CYCLES, default 21, idle phase-bus clocks between operations (at least 750 ns).
REQ-004 clock  in  1  system clock; all logic on posedge.
REQ-005 reset  in  1  reset; asynchronous, active-high.
REQ-006 cmd_valid  in  1  parsed command available.
REQ-007 cmd_ready  out  1  scheduler accepts a command this cycle.
REQ-008 cmd_opcode  in  2  0=lamp reset, 1=write4, 2=read4, 3=adc4.
REQ-009 cmd_params  in  40  five parameter bytes; byte0 in bits [7:0].
REQ-010 cmd_type  in  2  command variant, passed through to the engines.
REQ-011 tx_busy  in  1  UART response transmitter busy.
REQ-012 lamp_card_reset_activate, substate_pb_i_write4_active, substate_pb_read4_active, substate_pb_adc4_active  out  1 each  engine run requests.
REQ-013 lamp_card_reset_complete, substate_pb_i_write4_complete, substate_pb_read4_complete, substate_pb_adc4_complete  in  1 each  engine done flags.
REQ-014 command_param_data  out  40  latched parameters to the engines.
REQ-015 CommandType  out  2  latched cmd_type.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 error  out  1  sticky error flag.
REQ-018 error_code  out  2  0=none, 1=timeout, 2=init timeout.
REQ-019 cmd_count  out  8  count of completed commands; wraps 255->0.

Function
REQ-020 States: INIT_RUN, INIT_GAP, IDLE, ACTIVE, RELEASE, GAP, ABORT.
REQ-021 After reset the state is INIT_RUN, with lamp_card_reset_activate=1 and the timer running.
REQ-022 INIT_RUN: on lamp_card_reset_complete, go to RELEASE and then INIT_GAP; on timeout, go to ABORT with error_code=2.
REQ-023 INIT_GAP and GAP: count GAP_CYCLES clocks, then go to IDLE.
REQ-024 IDLE: cmd_ready = !tx_busy; cmd_ready is 0 in every other state.
REQ-025 A command is accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-026 On accept: latch opcode, cmd_params and cmd_type; clear error and error_code; go to ACTIVE.
REQ-027 ACTIVE: exactly one activate output is high, selected by the latched opcode, starting the cycle after accept.
REQ-028 ACTIVE: the timer increments each clock from 0.
REQ-029 ACTIVE: complete inputs of non-selected engines are ignored.
REQ-030 ACTIVE: when the selected complete is 1, go to RELEASE next cycle and increment cmd_count.
REQ-031 ACTIVE: if the timer reaches TIMEOUT_CYCLES-1 without completion, go to ABORT with error_code=1; cmd_count is not incremented.
REQ-032 If completion and timeout occur in the same cycle, completion wins.
REQ-033 RELEASE: all activates are 0; stay until the selected complete is 0, bounded by the timer; if the bound expires, go to ABORT.
REQ-034 ABORT: all activates are 0 and error=1 for one cycle, then go to GAP.
REQ-035 command_param_data and CommandType stay stable from accept until the next accept.
REQ-036 At most one activate output is high in any cycle.
REQ-037 The timer is sized $clog2(TIMEOUT_CYCLES)+1 bits and clears on every state entry.
REQ-038 cmd_valid outside IDLE has no effect; the command is not lost, because ready is low.

Reset
REQ-039 Reset asserted sets the state to INIT_RUN, all activates=0, cmd_ready=0, busy=1, error=0, error_code=0, cmd_count=0, command_param_data=0, CommandType=0, and clears the timer.
REQ-040 The first lamp_card_reset_activate occurs on the first clock after reset deasserts.
REQ-041 Reset asserted mid-operation drops every activate immediately, without waiting for a clock edge.

Verification
REQ-042 Release reset, pulse lamp_card_reset_complete at cycle 5 -> lamp activate is high for cycles 1-5, the block enters IDLE 21 clocks after RELEASE, cmd_ready=1, cmd_count=0.
REQ-043 In IDLE, send opcode 2 with params 0x0102030405, and complete at 10 cycles -> only substate_pb_read4_active is high; command_param_data=0x0102030405; cmd_count=1.
REQ-044 Send opcode 1 with no complete for 27000 clocks -> ABORT; error=1; error_code=1; cmd_count is unchanged; the next accept clears error.
REQ-045 With opcode 3 active, pulse substate_pb_read4_complete -> it is ignored and adc4 activate stays high until adc4 complete.
REQ-046 In IDLE with tx_busy=1 and cmd_valid=1 -> cmd_ready=0; when tx_busy drops, the command is accepted on the next edge.
REQ-047 Assert reset during ACTIVE -> all activates are 0 before the next clock edge; after release, the INIT_RUN sequence repeats.
